// File: rtl/mealy_table_pkg.sv
// Shared types and helpers for the table-driven Mealy FSM.
package mealy_table_pkg;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_STEP,
    ACT_RESTART
  } act_e;

  // Flat table index for {state, in}
  function automatic int unsigned entry_addr(input int unsigned state,
                                             input int unsigned in_sym,
                                             input int unsigned in_w);
    return (state << in_w) | in_sym;
  endfunction

  // An entry (or state) field is legal when it names an existing state
  function automatic bit entry_legal(input int unsigned next,
                                     input int unsigned num_states);
    return next < num_states;
  endfunction

endpackage

// File: rtl/mealy_table_mem.sv
// Transition/output table: async reset-init to self-loops, one write port,
// a combinational lookup port and a registered readback port.
module mealy_table_mem
  import mealy_table_pkg::*;
#(
  parameter int STATE_W     = 2,
  parameter int IN_W        = 2,
  parameter int OUT_W       = 2,
  parameter int DEFAULT_OUT = 0,
  localparam int A_W   = STATE_W + IN_W,
  localparam int E_W   = STATE_W + OUT_W,
  localparam int DEPTH = 2 ** A_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [A_W-1:0] waddr,
  input  logic [E_W-1:0] wdata,
  input  logic [A_W-1:0] laddr,
  output logic [E_W-1:0] ldata,
  input  logic [A_W-1:0] raddr,
  output logic [E_W-1:0] rdata
);

  logic [E_W-1:0] tbl [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Every entry points back at the state it belongs to
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl[i] <= {STATE_W'(i >> IN_W), OUT_W'(DEFAULT_OUT)};
      end
      rdata <= '0;
    end else begin
      if (we) tbl[waddr] <= wdata;
      rdata <= tbl[raddr];
    end
  end

  assign ldata = tbl[laddr];

endmodule

// File: rtl/mealy_table_fsm.sv
// Generalised Mealy FSM whose next-state/output function lives in a
// runtime-programmable table; adds restart, a saturating transition counter and cfg_err.
module mealy_table_fsm
  import mealy_table_pkg::*;
#(
  parameter int NUM_STATES  = 4,
  parameter int IN_W        = 2,
  parameter int OUT_W       = 2,
  parameter int RESET_STATE = 0,
  parameter int DEFAULT_OUT = 0,
  parameter int CNT_W       = 16,
  localparam int STATE_W    = $clog2(NUM_STATES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     restart,
  input  logic [IN_W-1:0]          in,
  output logic [OUT_W-1:0]         out,
  output logic [STATE_W-1:0]       state,
  input  logic                     cfg_we,
  input  logic [STATE_W+IN_W-1:0]  cfg_addr,
  input  logic [STATE_W+OUT_W-1:0] cfg_wdata,
  output logic [STATE_W+OUT_W-1:0] cfg_rdata,
  output logic                     cfg_err,
  output logic [CNT_W-1:0]         trans_count
);

  typedef struct packed {
    logic [STATE_W-1:0] next;
    logic [OUT_W-1:0]   out;
  } entry_t;

  localparam logic [STATE_W-1:0] RST_ST  = STATE_W'(RESET_STATE);
  localparam logic [OUT_W-1:0]   DEF_OUT = OUT_W'(DEFAULT_OUT);

  entry_t                    e;
  act_e                      act;
  logic [STATE_W-1:0]        state_d;
  logic [STATE_W+IN_W-1:0]   look_addr;
  logic                      wr_ok;

  assign look_addr = (STATE_W + IN_W)'(entry_addr(32'(state), 32'(in), IN_W));

  assign wr_ok = entry_legal(32'(cfg_wdata[STATE_W+OUT_W-1:OUT_W]), NUM_STATES) &&
                 entry_legal(32'(cfg_addr[STATE_W+IN_W-1:IN_W]), NUM_STATES);

  mealy_table_mem #(
    .STATE_W     (STATE_W),
    .IN_W        (IN_W),
    .OUT_W       (OUT_W),
    .DEFAULT_OUT (DEFAULT_OUT)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we && wr_ok),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .laddr (look_addr),
    .ldata (e),
    .raddr (cfg_addr),
    .rdata (cfg_rdata)
  );

  always_comb begin
    act     = ACT_HOLD;
    state_d = state;
    out     = DEF_OUT;
    if (en) out = e.out;
    if (restart)  act = ACT_RESTART;
    else if (en)  act = ACT_STEP;
    case (act)
      ACT_RESTART: state_d = RST_ST;
      ACT_STEP:    state_d = e.next;
      default:     state_d = state;
    endcase
    // Never let an out-of-range code reach the state register
    if (!entry_legal(32'(state_d), NUM_STATES)) state_d = RST_ST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_ST;
      trans_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_d;
      cfg_err <= cfg_we && !wr_ok;
      if (state_d != state && trans_count != '1) trans_count <= trans_count + CNT_W'(1);
    end
  end

  ap_legal_next: assert property (@(posedge clk) disable iff (rst)
    (act == ACT_STEP) |-> entry_legal(32'(e.next), NUM_STATES));

endmodule

// File: tb/tb_mealy_table_fsm.sv
// Self-checking bench: two instances (4 states/16-bit counter, 3 states/4-bit counter)
// compared against a table-based reference model.
module tb_mealy_table_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en        [2];
  logic       restart   [2];
  logic [1:0] in_s      [2];
  logic       cfg_we    [2];
  logic [3:0] cfg_addr  [2];
  logic [3:0] cfg_wdata [2];

  logic [1:0]  out_a, out_b, state_a, state_b;
  logic [3:0]  rdata_a, rdata_b, cnt_b;
  logic        err_a, err_b;
  logic [15:0] cnt_a;

  mealy_table_fsm u_a (
    .clk(clk), .rst(rst), .en(en[0]), .restart(restart[0]), .in(in_s[0]),
    .out(out_a), .state(state_a), .cfg_we(cfg_we[0]), .cfg_addr(cfg_addr[0]),
    .cfg_wdata(cfg_wdata[0]), .cfg_rdata(rdata_a), .cfg_err(err_a), .trans_count(cnt_a)
  );

  mealy_table_fsm #(.NUM_STATES(3), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .en(en[1]), .restart(restart[1]), .in(in_s[1]),
    .out(out_b), .state(state_b), .cfg_we(cfg_we[1]), .cfg_addr(cfg_addr[1]),
    .cfg_wdata(cfg_wdata[1]), .cfg_rdata(rdata_b), .cfg_err(err_b), .trans_count(cnt_b)
  );

  localparam int F_OUT = 0, F_ST = 1, F_CNT = 2, F_RD = 3, F_ERR = 4;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: per instance, next/out per {state,in} entry, state, count
  int m_nx [2][16];
  int m_ou [2][16];
  int m_st [2];
  int m_cnt[2];
  int ns   [2] = '{4, 3};
  int cmax [2] = '{65535, 15};

  function automatic logic [31:0] obs(input int w, input int f);
    case (f)
      F_OUT:   return (w == 0) ? 32'(out_a)   : 32'(out_b);
      F_ST:    return (w == 0) ? 32'(state_a) : 32'(state_b);
      F_CNT:   return (w == 0) ? 32'(cnt_a)   : 32'(cnt_b);
      F_RD:    return (w == 0) ? 32'(rdata_a) : 32'(rdata_b);
      default: return (w == 0) ? 32'(err_a)   : 32'(err_b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input int exp);
    n_chk++;
    assert (o === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int v = 0; v < 2; v++) begin
      en[v] = 1'b0; restart[v] = 1'b0; in_s[v] = '0;
      cfg_we[v] = 1'b0; cfg_addr[v] = '0; cfg_wdata[v] = '0;
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_st[w] = 0; m_cnt[w] = 0;
      for (int k = 0; k < 16; k++) begin m_nx[w][k] = k / 4; m_ou[w][k] = 0; end
    end
  endtask

  // Entered at posedge+1; asserts rst asynchronously and checks reset values
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    model_reset();
    for (int w = 0; w < 2; w++) begin
      chk("rst_state", obs(w, F_ST), 0);
      chk("rst_cnt",   obs(w, F_CNT), 0);
      chk("rst_rdata", obs(w, F_RD), 0);
      chk("rst_err",   obs(w, F_ERR), 0);
      chk("rst_out",   obs(w, F_OUT), 0);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One clock on instance w; entered and left at posedge+1
  task automatic step(input int w, input bit e, input bit r, input int i,
                      input bit we, input int addr, input int wd);
    int s, idx, nxt, exp_rd;
    bit ok, exp_err;
    string p;
    p = (w == 0) ? "a" : "b";
    idle_inputs();
    en[w] = e; restart[w] = r; in_s[w] = 2'(i);
    cfg_we[w] = we; cfg_addr[w] = 4'(addr); cfg_wdata[w] = 4'(wd);
    #4;
    s   = m_st[w];
    idx = s * 4 + i;
    chk({p, "_out"}, obs(w, F_OUT), e ? m_ou[w][idx] : 0);
    exp_rd  = m_nx[w][addr] * 4 + m_ou[w][addr];
    nxt     = r ? 0 : (e ? m_nx[w][idx] : s);
    ok      = (wd / 4 < ns[w]) && (addr / 4 < ns[w]);
    exp_err = we && !ok;
    @(posedge clk); #1;
    if (we && ok) begin m_nx[w][addr] = wd / 4; m_ou[w][addr] = wd % 4; end
    if (nxt != s && m_cnt[w] < cmax[w]) m_cnt[w]++;
    m_st[w] = nxt;
    chk({p, "_state"}, obs(w, F_ST),  m_st[w]);
    chk({p, "_cnt"},   obs(w, F_CNT), m_cnt[w]);
    chk({p, "_rdata"}, obs(w, F_RD),  exp_rd);
    chk({p, "_err"},   obs(w, F_ERR), int'(exp_err));
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    @(posedge clk); #1;
    do_reset();

    // Unprogrammed table: self-loops, default output, no transitions
    for (int k = 0; k < 8; k++) step(0, 1, 0, $urandom_range(0, 3), 0, 0, 0);
    chk("unprog_cnt", obs(0, F_CNT), 0);

    // Blue(0)/Red(1) controller
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++)
        step(0, 0, 0, 0, 1, s * 4 + i,
             (s == 0) ? ((i == 1) ? 6 : 1) : ((i == 1) ? 1 : 6));
    step(0, 1, 0, 1, 0, 5, 0);        // Blue -> Red
    chk("br_red", obs(0, F_ST), 1);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("br_final", obs(0, F_ST), 1);

    // Rewrite the live entry {Red,0}: this cycle sees old data, next visit new
    step(0, 1, 0, 0, 1, 4, 3);
    step(0, 1, 0, 0, 0, 4, 0);
    chk("live_new", obs(0, F_ST), 0);

    // restart beats en from state 2, then restart in reset state does not count
    step(0, 0, 0, 0, 1, 2, 8);
    step(0, 1, 0, 2, 0, 0, 0);
    chk("to_s2", obs(0, F_ST), 2);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);

    // Random traffic on the 4-state instance
    for (int k = 0; k < 150; k++)
      step(0, $urandom_range(0, 1), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));

    // 3-state instance: rejected writes (bad next, bad state) and a legal one
    step(1, 0, 0, 0, 1, 1, 13);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 13, 1);
    step(1, 0, 0, 0, 1, 1, 9);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);

    for (int k = 0; k < 150; k++)
      step(1, $urandom_range(0, 1), ($urandom_range(0, 9) == 0), $urandom_range(0, 3),
           $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));

    // Toggling table on the 4-bit counter: saturates at 15
    do_reset();
    for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 1, k, 5);
    for (int k = 4; k < 8; k++) step(1, 0, 0, 0, 1, k, 2);
    for (int k = 0; k < 20; k++) step(1, 1, 0, $urandom_range(0, 3), 0, 0, 0);
    chk("sat_cnt", obs(1, F_CNT), 15);

    // Mid-run reset restores state, counter and table
    step(1, 1, 0, 0, 0, 0, 0);
    do_reset();
    for (int k = 0; k < 16; k++) step(1, 0, 0, 0, 0, k, 0);
    for (int k = 0; k < 16; k++) step(0, 0, 0, 0, 0, k, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
